// File: rtl/fetch_stage_unit.sv
// ---------------------------------------------------------------------------
// fetch_stage_unit
//
// Instruction-fetch stage. Owns the program counter, issues word fetches to
// instruction memory over a req/ack handshake, buffers the returned word and
// presents it together with its PC+4 to the IF/ID pipeline register. Honours
// IF/ID stalls (LE low) and redirects on taken branches, squashing any
// in-flight or buffered wrong-path fetch.
//
// Ports:
//   Clk            pipeline clock, all state updates on posedge
//   R              asynchronous active-low reset
//   LE             IF/ID load enable (0 = stall, hold buffered instruction)
//   branch_taken   taken-branch redirect, valid this cycle
//   branch_target  redirect address (bits [1:0] forced to 0)
//   imem_req       fetch request to instruction memory
//   imem_addr      fetch address, stable while imem_req=1 and imem_ack=0
//   imem_ack       memory completes the request this cycle
//   imem_rdata     fetched instruction word
//   instr_out      instruction to IF/ID (0 when no valid instruction)
//   next_pc_out    PC+4 of instr_out (0 when no valid instruction)
//   instr_valid    instr_out / next_pc_out carry a real instruction
//   pc             current PC, for debug
// ---------------------------------------------------------------------------
module fetch_stage_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        R,
    input  logic        LE,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] next_pc_out,
    output logic        instr_valid,
    output logic [31:0] pc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [31:0] redirect_pc;
    logic [31:0] instr_buf;
    logic        squash;
    logic [31:0] target_aligned;
    logic [31:0] pc_plus4;

    assign target_aligned = branch_target & ~32'h3;
    assign pc_plus4       = pc + 32'd4;   // wraps modulo 2^32

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge Clk or negedge R) begin
        if (!R) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  state_next = FETCH;
            // A squashed or redirected ack stays in FETCH to issue the new
            // address next cycle; only a clean ack delivers an instruction.
            FETCH: if (imem_ack && !squash && !branch_taken) state_next = VALID;
            VALID: if (branch_taken || LE) state_next = FETCH;
            default: state_next = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    // NOTE: every register here, including the instruction buffer, is reset
    // so the bubble/reset encodings are well defined from the first cycle.
    always_ff @(posedge Clk or negedge R) begin
        if (!R) begin
            pc          <= RESET_PC;
            redirect_pc <= 32'h0;
            instr_buf   <= 32'h0;
            squash      <= 1'b0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (imem_ack) begin
                        if (squash || branch_taken) begin
                            // Wrong-path data: drop it and retarget.
                            pc     <= branch_taken ? target_aligned : redirect_pc;
                            squash <= 1'b0;
                        end else begin
                            instr_buf <= imem_rdata;
                        end
                    end else if (branch_taken) begin
                        // Request is in flight; the address must stay stable
                        // until ack, so remember where to go afterwards.
                        redirect_pc <= target_aligned;
                        squash      <= 1'b1;
                    end
                end
                VALID: begin
                    // Branch wins over LE: the buffered word is wrong-path.
                    if (branch_taken) begin
                        pc <= target_aligned;
                    end else if (LE) begin
                        pc <= pc_plus4;
                    end
                end
                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: decoded from state and registers only
    // -----------------------------------------------------------------------
    assign imem_req    = (state == FETCH);
    assign imem_addr   = (state == FETCH) ? pc : 32'h0;
    assign instr_valid = (state == VALID);
    // Invalid cycles present a zero bubble, matching the IF/ID reset value.
    assign instr_out   = (state == VALID) ? instr_buf : 32'h0;
    assign next_pc_out = (state == VALID) ? pc_plus4  : 32'h0;

endmodule

// File: tb/tb_fetch_stage_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage_unit
//
// Directed bench for fetch_stage_unit with RESET_PC = 0x100. A table of
// per-cycle input/expected-output records drives the main sequence (sequential
// fetch, stall, branches, multi-cycle squashed fetch, PC wraparound); short
// hand-written sequences cover asynchronous reset during a pending fetch.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_fetch_stage_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'hE1A0_0000;

    logic        Clk;
    logic        R;
    logic        LE;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [31:0] next_pc_out;
    logic        instr_valid;
    logic [31:0] pc;

    int n_pass  = 0;
    int n_total = 0;

    fetch_stage_unit #(.RESET_PC(RST_PC)) dut (
        .Clk           (Clk),
        .R             (R),
        .LE            (LE),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_out     (instr_out),
        .next_pc_out   (next_pc_out),
        .instr_valid   (instr_valid),
        .pc            (pc)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        le;
        logic        bt;
        logic [31:0] tgt;
        logic        ack;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_npc;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_outputs(input string tag, input logic e_req, input logic [31:0] e_addr,
                                 input logic e_valid, input logic [31:0] e_instr,
                                 input logic [31:0] e_npc, input logic [31:0] e_pc);
        check({tag, ".imem_req"},    {31'h0, imem_req},    {31'h0, e_req});
        check({tag, ".imem_addr"},   imem_addr,            e_addr);
        check({tag, ".instr_valid"}, {31'h0, instr_valid}, {31'h0, e_valid});
        check({tag, ".instr_out"},   instr_out,            e_instr);
        check({tag, ".next_pc_out"}, next_pc_out,          e_npc);
        check({tag, ".pc"},          pc,                   e_pc);
    endtask

    task automatic drive(input logic le, input logic bt, input logic [31:0] tgt,
                         input logic ack, input logic [31:0] rd);
        LE            = le;
        branch_taken  = bt;
        branch_target = tgt;
        imem_ack      = ack;
        imem_rdata    = rd;
    endtask

    initial begin
        //             le   bt   tgt           ack  rd            req  addr          vld  instr         npc           pc
        // Sequential fetch from reset (ack in IDLE is ignored).
        vecs.push_back('{1'b1,1'b0,32'h0,        1'b1,32'hBAD0_0000, 1'b0,32'h0,        1'b0,32'h0,        32'h0,        32'h100});
        vecs.push_back('{1'b1,1'b0,32'h0,        1'b1,NOP,          1'b1,32'h100,      1'b0,32'h0,        32'h0,        32'h100});
        vecs.push_back('{1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b1,NOP,          32'h104,      32'h100});
        vecs.push_back('{1'b1,1'b0,32'h0,        1'b1,32'h1111_1111, 1'b1,32'h104,      1'b0,32'h0,        32'h0,        32'h104});
        vecs.push_back('{1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h1111_1111,32'h108,      32'h104});
        vecs.push_back('{1'b1,1'b0,32'h0,        1'b1,32'h2222_2222, 1'b1,32'h108,      1'b0,32'h0,        32'h0,        32'h108});
        // Stall for three cycles, then release; ack in VALID is ignored.
        vecs.push_back('{1'b0,1'b0,32'h0,        1'b1,32'hBAD1_1111, 1'b0,32'h0,        1'b1,32'h2222_2222,32'h10C,      32'h108});
        vecs.push_back('{1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h2222_2222,32'h10C,      32'h108});
        vecs.push_back('{1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h2222_2222,32'h10C,      32'h108});
        vecs.push_back('{1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h2222_2222,32'h10C,      32'h108});
        vecs.push_back('{1'b1,1'b0,32'h0,        1'b1,32'h3333_3333, 1'b1,32'h10C,      1'b0,32'h0,        32'h0,        32'h10C});
        // Branch in VALID with LE=1 to unaligned 0x203 -> next fetch at 0x200.
        vecs.push_back('{1'b1,1'b1,32'h203,      1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h3333_3333,32'h110,      32'h10C});
        // Ack coinciding with a branch: data dropped, redirect to 0x10.
        vecs.push_back('{1'b1,1'b1,32'h10,       1'b1,32'hBAD2_2222, 1'b1,32'h200,      1'b0,32'h0,        32'h0,        32'h200});
        // 3-cycle-latency fetch at 0x10, branch to 0x80 in the wait.
        vecs.push_back('{1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h10,       1'b0,32'h0,        32'h0,        32'h10});
        vecs.push_back('{1'b1,1'b1,32'h80,       1'b0,32'h0,        1'b1,32'h10,       1'b0,32'h0,        32'h0,        32'h10});
        vecs.push_back('{1'b1,1'b0,32'h0,        1'b1,32'hDEAD_BEEF, 1'b1,32'h10,       1'b0,32'h0,        32'h0,        32'h10});
        vecs.push_back('{1'b1,1'b0,32'h0,        1'b1,32'h4444_4444, 1'b1,32'h80,       1'b0,32'h0,        32'h0,        32'h80});
        // Branch beats a stall; target 0xFFFFFFFE aligns to 0xFFFFFFFC.
        vecs.push_back('{1'b0,1'b1,32'hFFFF_FFFE,1'b1,32'hBAD3_3333, 1'b0,32'h0,        1'b1,32'h4444_4444,32'h84,       32'h80});
        vecs.push_back('{1'b1,1'b0,32'h0,        1'b1,32'h5555_5555, 1'b1,32'hFFFF_FFFC,1'b0,32'h0,        32'h0,        32'hFFFF_FFFC});
        // PC wraparound.
        vecs.push_back('{1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h5555_5555,32'h0,        32'hFFFF_FFFC});
        vecs.push_back('{1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h0,        1'b0,32'h0,        32'h0,        32'h0});
        // Leave a squash pending so reset must clear it.
        vecs.push_back('{1'b1,1'b1,32'h300,      1'b0,32'h0,        1'b1,32'h0,        1'b0,32'h0,        32'h0,        32'h0});

        // Reset state.
        R = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check_outputs("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, RST_PC);
        R = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].le, vecs[i].bt, vecs[i].tgt, vecs[i].ack, vecs[i].rd);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                          vecs[i].e_valid, vecs[i].e_instr, vecs[i].e_npc, vecs[i].e_pc);
            @(posedge Clk);
            @(negedge Clk);
        end

        // Async reset mid-FETCH: outputs must fall before the next edge.
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        #2 R = 1'b0;
        #1 check_outputs("async_rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, RST_PC);
        // A late ack while reset is held is ignored.
        drive(1'b1, 1'b0, 32'h0, 1'b1, 32'hBAD4_4444);
        @(posedge Clk);
        @(negedge Clk);
        check_outputs("rst_hold", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, RST_PC);

        // Restart: IDLE, then fetch from RESET_PC; the pre-reset squash is gone.
        R = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        #1 check_outputs("restart_idle", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, RST_PC);
        @(posedge Clk);
        @(negedge Clk);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h6666_6666);
        #1 check_outputs("restart_fetch", 1'b1, RST_PC, 1'b0, 32'h0, 32'h0, RST_PC);
        @(posedge Clk);
        @(negedge Clk);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1 check_outputs("restart_valid", 1'b0, 32'h0, 1'b1, 32'h6666_6666, RST_PC + 32'd4, RST_PC);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
